// File: rtl/crc8_checker.sv
// -----------------------------------------------------------------------------
// crc8_checker
// Receives a serial frame (DATA_BITS payload bits followed by an 8-bit CRC
// field, MSB first) and checks it with a bit-serial CRC-8 LFSR.
//
// Running the LFSR over both the payload and the transmitted CRC leaves a zero
// remainder for an intact frame. The LFSR starts at INIT and there is no final
// XOR.
//
// Parameters
//   DATA_BITS : payload bits per frame (1..1024)
//   POLY      : generator polynomial, implicit x^8 term omitted
//   INIT      : LFSR value loaded at frame start
//
// Ports
//   clk      in   clock, all state changes on the rising edge
//   reset    in   synchronous active-high reset
//   start    in   frame start; while receiving it aborts and restarts the frame
//   data     in   serial bit, MSB first
//   enable   in   bit-valid qualifier
//   busy     out  high while a frame is being received
//   done     out  one-cycle pulse in the cycle after the last frame bit
//   crc_ok   out  last completed frame had a zero remainder
//   crc_err  out  last completed frame had a non-zero remainder
//   rx_data  out  payload of the last frame; the first bit received is the MSB
//   rx_crc   out  CRC field of the last frame; the first bit received is bit 7
// -----------------------------------------------------------------------------
module crc8_checker #(
    parameter int          DATA_BITS = 16,
    parameter logic [7:0]  POLY      = 8'h07,
    parameter logic [7:0]  INIT      = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 data,
    input  logic                 enable,
    output logic                 busy,
    output logic                 done,
    output logic                 crc_ok,
    output logic                 crc_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic [7:0]           rx_crc
);

    localparam int CNT_W = $clog2(DATA_BITS + 9);

    // Counter value of the first CRC-field bit, and of the last bit in the frame.
    localparam logic [CNT_W-1:0] PAY_LEN  = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS + 7);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    // One bit-serial CRC-8 step: feedback is the LFSR MSB XOR the incoming bit.
    function automatic logic [7:0] crc8_step(input logic [7:0] lfsr, input logic bit_in);
        logic       fb;
        logic [7:0] shifted;
        fb      = lfsr[7] ^ bit_in;
        shifted = {lfsr[6:0], 1'b0};
        if (fb) begin
            crc8_step = shifted ^ POLY;
        end else begin
            crc8_step = shifted;
        end
    endfunction

    state_t                 state_r;
    logic [7:0]             lfsr_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [DATA_BITS-1:0]   data_sr_r;
    logic [7:0]             crc_sr_r;

    logic [7:0]             lfsr_next_s;
    logic                   accept_s;

    // Next LFSR value and the bit-accept qualifier.
    // A start pulse always takes priority over the bit presented with it.
    always_comb begin
        lfsr_next_s = crc8_step(lfsr_r, data);
        accept_s    = 1'b0;
        if ((state_r == RECV) && enable && !start) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Receive FSM, shift registers, and registered result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            lfsr_r    <= INIT;
            cnt_r     <= '0;
            data_sr_r <= '0;
            crc_sr_r  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            crc_ok    <= 1'b0;
            crc_err   <= 1'b0;
            rx_data   <= '0;
            rx_crc    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= RECV;
                        busy    <= 1'b1;
                        lfsr_r  <= INIT;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RECV: begin
                    if (start) begin
                        // Abort the current frame and restart; the results are left unchanged.
                        lfsr_r <= INIT;
                        cnt_r  <= '0;
                    end else if (accept_s) begin
                        lfsr_r <= lfsr_next_s;
                        cnt_r  <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r < PAY_LEN) begin
                            // The cast keeps the low DATA_BITS bits, so one-bit payloads also work.
                            data_sr_r <= DATA_BITS'({data_sr_r, data});
                        end else begin
                            crc_sr_r <= {crc_sr_r[6:0], data};
                        end
                        if (cnt_r == LAST_IDX) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            crc_ok  <= (lfsr_next_s == 8'h00);
                            crc_err <= (lfsr_next_s != 8'h00);
                            rx_data <= data_sr_r;
                            rx_crc  <= {crc_sr_r[6:0], data};
                        end else begin
                            state_r <= RECV;
                        end
                    end else begin
                        // Gap: hold the LFSR, the counter and the state.
                        state_r <= RECV;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_checker.sv
// -----------------------------------------------------------------------------
// tb_crc8_checker
// Directed, table-driven bench for crc8_checker (DATA_BITS=16, POLY=8'h07,
// INIT=8'h00). Each table row holds a frame and its hand-computed verdict.
// Hand-written sequences cover the gap, restart, back-to-back and mid-frame
// reset cases.
// -----------------------------------------------------------------------------
module tb_crc8_checker;

    logic        clk;
    logic        reset;
    logic        start;
    logic        data;
    logic        enable;
    logic        busy;
    logic        done;
    logic        crc_ok;
    logic        crc_err;
    logic [15:0] rx_data;
    logic [7:0]  rx_crc;

    int n_checks;
    int n_fail;
    int done_cnt;

    typedef struct {
        logic [15:0] payload;
        logic [7:0]  crc;
        logic        exp_ok;
        logic        exp_err;
    } vec_t;

    vec_t vecs [5];

    crc8_checker #(
        .DATA_BITS(16),
        .POLY(8'h07),
        .INIT(8'h00)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .data(data),
        .enable(enable),
        .busy(busy),
        .done(done),
        .crc_ok(crc_ok),
        .crc_err(crc_err),
        .rx_data(rx_data),
        .rx_crc(rx_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses. At each edge this sees the value done held in the previous cycle.
    initial done_cnt = 0;
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Hard time limit on the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start, then all 24 frame bits. The start cycle carries a junk enabled bit,
    // which the DUT must discard. Optional gaps: 3 cycles after bit 5 and 1 cycle
    // after bit 17. This task returns right after the last-bit edge, without an
    // idle cycle.
    task automatic run_frame(input logic [15:0] pl, input logic [7:0] cf, input bit gapped,
                             input logic prev_ok, input logic prev_err, output int cyc);
        logic [23:0] fr;
        fr  = {pl, cf};
        cyc = 0;
        start = 1'b1; enable = 1'b1; data = 1'b1;
        tick(); cyc++;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("ok_hold_on_start", {31'd0, crc_ok}, {31'd0, prev_ok});
        check("err_hold_on_start", {31'd0, crc_err}, {31'd0, prev_err});
        start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            data = fr[23-i]; enable = 1'b1;
            tick(); cyc++;
            if (gapped && i == 4) begin
                for (int g = 0; g < 3; g++) begin
                    enable = 1'b0; data = ~data;
                    tick(); cyc++;
                end
            end
            if (gapped && i == 16) begin
                enable = 1'b0;
                tick(); cyc++;
            end
        end
        enable = 1'b0; data = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v, input int cyc, input int exp_cyc);
        check({tag, "_done"},    {31'd0, done},    32'd1);
        check({tag, "_latency"}, cyc,              exp_cyc);
        check({tag, "_ok"},      {31'd0, crc_ok},  {31'd0, v.exp_ok});
        check({tag, "_err"},     {31'd0, crc_err}, {31'd0, v.exp_err});
        check({tag, "_rx_data"}, {16'd0, rx_data}, {16'd0, v.payload});
        check({tag, "_rx_crc"},  {24'd0, rx_crc},  {24'd0, v.crc});
        check({tag, "_busy"},    {31'd0, busy},    32'd0);
    endtask

    initial begin
        int   cyc;
        int   base;
        logic p_ok;
        logic p_err;
        logic [9:0] junk;
        vec_t gv;

        n_checks = 0;
        n_fail   = 0;

        // CRC-8 (poly 0x07, init 0x00, no final XOR), computed by hand.
        vecs[0] = '{16'hECB5, 8'hBD, 1'b1, 1'b0};
        vecs[1] = '{16'hFFFF, 8'h24, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 8'h01, 1'b0, 1'b1};
        vecs[3] = '{16'h0000, 8'h00, 1'b1, 1'b0};
        vecs[4] = '{16'hECB5, 8'hBC, 1'b0, 1'b1};

        // Reset held for 2 cycles.
        reset = 1'b1; start = 1'b0; enable = 1'b0; data = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_busy",    {31'd0, busy},    32'd0);
        check("rst_done",    {31'd0, done},    32'd0);
        check("rst_ok",      {31'd0, crc_ok},  32'd0);
        check("rst_err",     {31'd0, crc_err}, 32'd0);
        check("rst_rx_data", {16'd0, rx_data}, 32'd0);
        check("rst_rx_crc",  {24'd0, rx_crc},  32'd0);

        // enable is ignored while idle.
        enable = 1'b1; data = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b0;
        check("idle_busy",    {31'd0, busy},    32'd0);
        check("idle_rx_data", {16'd0, rx_data}, 32'd0);
        check("idle_ok",      {31'd0, crc_ok},  32'd0);

        // Table-driven frames.
        p_ok = 1'b0; p_err = 1'b0;
        for (int k = 0; k < 5; k++) begin
            base = done_cnt;
            run_frame(vecs[k].payload, vecs[k].crc, 1'b0, p_ok, p_err, cyc);
            check_result("vec", vecs[k], cyc, 25);
            tick();
            check("vec_done_low", {31'd0, done},   32'd0);
            check("vec_ok_hold",  {31'd0, crc_ok}, {31'd0, vecs[k].exp_ok});
            check("vec_one_pulse", done_cnt - base, 1);
            p_ok = vecs[k].exp_ok; p_err = vecs[k].exp_err;
        end

        // Gapped good frame: done comes 4 cycles later than with no gaps.
        gv = vecs[0];
        base = done_cnt;
        run_frame(gv.payload, gv.crc, 1'b1, p_ok, p_err, cyc);
        check_result("gap", gv, cyc, 29);
        tick();
        check("gap_one_pulse", done_cnt - base, 1);
        p_ok = 1'b1; p_err = 1'b0;

        // Restart: begin after a corrupt frame, so that crc_ok flipping back to 1 means something.
        run_frame(vecs[4].payload, vecs[4].crc, 1'b0, p_ok, p_err, cyc);
        tick();
        base = done_cnt;
        junk = 10'b1011001110;
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data = junk[9-i]; enable = 1'b1; tick();
        end
        run_frame(gv.payload, gv.crc, 1'b0, 1'b0, 1'b1, cyc);
        check_result("restart", gv, cyc, 25);
        tick();
        check("restart_one_pulse", done_cnt - base, 1);

        // Back-to-back: the next start is asserted in the cycle where done is high.
        base = done_cnt;
        run_frame(vecs[1].payload, vecs[1].crc, 1'b0, 1'b1, 1'b0, cyc);
        check("b2b_first_done", {31'd0, done}, 32'd1);
        run_frame(vecs[2].payload, vecs[2].crc, 1'b0, 1'b1, 1'b0, cyc);
        check_result("b2b", vecs[2], cyc, 25);
        tick();
        check("b2b_two_pulses", done_cnt - base, 2);

        // Reset in mid-frame: no done pulse; the outputs return to 0 and stay there.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            data = gv.payload[15-i]; enable = 1'b1; tick();
        end
        base = done_cnt;
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data = i[0]; enable = 1'b1; tick();
        end
        enable = 1'b0;
        tick();
        check("mrst_no_done", done_cnt - base, 0);
        check("mrst_busy",    {31'd0, busy},    32'd0);
        check("mrst_ok",      {31'd0, crc_ok},  32'd0);
        check("mrst_err",     {31'd0, crc_err}, 32'd0);
        check("mrst_rx_data", {16'd0, rx_data}, 32'd0);
        check("mrst_rx_crc",  {24'd0, rx_crc},  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
